// File: rtl/sev_segment_pkg.sv
// sev_segment_pkg
//   Constants shared by the seven-segment encoder and the capture path:
//   segment patterns {a,b,c,d,e,f,g} (a = bit 6, active-high), the BCD
//   codes used for blank and unrecognised digits, and the capture FSM
//   state type.
package sev_segment_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

  // Per-sample capture state: WAIT until a digit has dwelt long enough,
  // LOCKED afterwards so one dwell yields exactly one capture.
  typedef enum logic {
    WAIT   = 1'b0,
    LOCKED = 1'b1
  } cap_state_t;

endpackage

// File: rtl/sev_segment_decode.sv
// sev_segment_decode
//   Combinational inverse of the BCD-to-seven-segment encoder.
//   Ports:
//     seg  in  7  segment pattern {a,b,c,d,e,f,g}, a = bit 6
//     bcd  out 4  decoded digit; 4'hF for blank, 4'hE for unrecognised
//     err  out 1  set when the pattern is not a digit and not blank
module sev_segment_decode
  import sev_segment_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       err
);

  always_comb begin
    // NOTE: every output gets a default before the case, so no path
    // leaves a value unassigned and no latch is inferred.
    bcd = BCD_ERR;
    err = 1'b1;
    case (seg)
      SEG_0:     begin bcd = 4'd0;      err = 1'b0; end
      SEG_1:     begin bcd = 4'd1;      err = 1'b0; end
      SEG_2:     begin bcd = 4'd2;      err = 1'b0; end
      SEG_3:     begin bcd = 4'd3;      err = 1'b0; end
      SEG_4:     begin bcd = 4'd4;      err = 1'b0; end
      SEG_5:     begin bcd = 4'd5;      err = 1'b0; end
      SEG_6:     begin bcd = 4'd6;      err = 1'b0; end
      SEG_7:     begin bcd = 4'd7;      err = 1'b0; end
      SEG_8:     begin bcd = 4'd8;      err = 1'b0; end
      SEG_9:     begin bcd = 4'd9;      err = 1'b0; end
      SEG_BLANK: begin bcd = BCD_BLANK; err = 1'b0; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/sev_segment_capture.sv
// sev_segment_capture
//   Watches a multiplexed seven-segment bus, captures each digit once its
//   pattern has settled, decodes it back to BCD and assembles one word per
//   scan frame, offered on a valid/ready port.
//   Parameters:
//     NUM_DIGITS     number of multiplexed digits (>= 2)
//     STABLE_CYCLES  identical registered samples needed to capture (>= 2)
//   Ports:
//     clk        in   system clock, rising edge
//     rst        in   synchronous active-high reset
//     seg        in   7           segment pattern, a = bit 6
//     dig_sel    in   NUM_DIGITS  one-hot digit select
//     out_ready  in   1           consumer accepts the frame
//     out_valid  out  1           frame available
//     bcd_out    out  4*NUM_DIGITS  digit i in bits [4i+3:4i]
//     err_mask   out  NUM_DIGITS  digit i held an unrecognised pattern
//     overrun    out  1           one-cycle pulse per dropped frame
module sev_segment_capture
  import sev_segment_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   err_mask,
  output logic                    overrun
);

  localparam int               CNT_W   = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Input register and the previous registered sample used for change
  // detection.
  logic [6:0]            s_seg, p_seg;
  logic [NUM_DIGITS-1:0] s_sel, p_sel;
  logic [CNT_W-1:0]      stab_cnt;
  logic [CNT_W-1:0]      stab_nxt;
  logic                  changed;

  cap_state_t            state;

  // Collected slots for the frame in progress.
  logic [4*NUM_DIGITS-1:0] slot_bcd;
  logic [NUM_DIGITS-1:0]   slot_err;
  logic [NUM_DIGITS-1:0]   seen;

  logic [3:0]            dec_bcd;
  logic                  dec_err;
  logic                  sel_onehot;
  logic                  capture;
  logic [NUM_DIGITS-1:0] cap_vec;
  logic                  frame_done;
  logic                  load;

  sev_segment_decode u_decode (
    .seg (s_seg),
    .bcd (dec_bcd),
    .err (dec_err)
  );

  always_comb begin
    changed    = ({s_seg, s_sel} != {p_seg, p_sel});
    stab_nxt   = stab_cnt;
    if (changed) begin
      stab_nxt = CNT_ONE;
    end else if (stab_cnt != CNT_MAX) begin
      stab_nxt = stab_cnt + CNT_ONE;
    end
    sel_onehot = $onehot(s_sel);
    // Capture on the edge at which the counter reaches its limit, hence the
    // look-ahead value rather than the registered one.
    capture    = (state == WAIT) && (stab_nxt == CNT_MAX) && sel_onehot;
    cap_vec    = capture ? s_sel : '0;
    frame_done = &seen;
    load       = frame_done && (!out_valid || out_ready);
  end

  // Input sampling and stability counting.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (rst) begin
      s_seg    <= '0;
      s_sel    <= '0;
      p_seg    <= '0;
      p_sel    <= '0;
      stab_cnt <= '0;
    end else begin
      s_seg    <= seg;
      s_sel    <= dig_sel;
      p_seg    <= s_seg;
      p_sel    <= s_sel;
      stab_cnt <= stab_nxt;
    end
  end

  // Capture FSM: one capture per dwell; any change of the sample re-arms.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT;
    end else begin
      case (state)
        WAIT:    if (capture) state <= LOCKED;
        LOCKED:  if (changed) state <= WAIT;
        default: state <= WAIT;
      endcase
    end
  end

  // Slot collection and frame assembly. A recapture before the frame
  // completes simply overwrites its slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the slot storage is reset along with the control state so the
      // datapath never holds X, even though a frame is only formed after
      // every slot has been written.
      slot_bcd <= {NUM_DIGITS{BCD_BLANK}};
      slot_err <= '0;
      seen     <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_vec[i]) begin
          slot_bcd[4*i +: 4] <= dec_bcd;
          slot_err[i]        <= dec_err;
        end
      end
      // The completed frame is handed off on this edge, so seen restarts
      // from whatever is being captured right now.
      seen <= frame_done ? cap_vec : (seen | cap_vec);
    end
  end

  // Output register with valid/ready handshake. A frame that cannot be
  // loaded because the held one is not being accepted is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      bcd_out   <= {NUM_DIGITS{BCD_BLANK}};
      err_mask  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        bcd_out   <= slot_bcd;
        err_mask  <= slot_err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      overrun <= frame_done && out_valid && !out_ready;
    end
  end

endmodule

// File: tb/tb_sev_segment_capture.sv
// tb_sev_segment_capture
//   Directed bench for sev_segment_capture (NUM_DIGITS=4, STABLE_CYCLES=4).
//   Expected frames are queued when the digits are driven and compared as
//   the DUT hands them over on the valid/ready port.
module tb_sev_segment_capture;

  localparam int ND = 4;

  localparam logic [6:0] P1 = 7'b0110000;
  localparam logic [6:0] P2 = 7'b1101101;
  localparam logic [6:0] P3 = 7'b1111001;
  localparam logic [6:0] P4 = 7'b0110011;
  localparam logic [6:0] P5 = 7'b1011011;
  localparam logic [6:0] P6 = 7'b1011111;
  localparam logic [6:0] P7 = 7'b1110000;
  localparam logic [6:0] P8 = 7'b1111111;
  localparam logic [6:0] P9 = 7'b1111011;
  localparam logic [6:0] PILL = 7'b1000000;
  localparam logic [6:0] PBLK = 7'b0000000;

  typedef struct {
    logic [4*ND-1:0] bcd;
    logic [ND-1:0]   err;
  } frame_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [6:0]      seg;
  logic [ND-1:0]   dig_sel;
  logic            out_ready;
  logic            out_valid;
  logic [4*ND-1:0] bcd_out;
  logic [ND-1:0]   err_mask;
  logic            overrun;

  int     checks   = 0;
  int     failures = 0;
  int     ovr_cnt  = 0;
  frame_t sb[$];

  sev_segment_capture #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seg       (seg),
    .dig_sel   (dig_sel),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .bcd_out   (bcd_out),
    .err_mask  (err_mask),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_raw(input logic [ND-1:0] sel, input logic [6:0] pat, input int n);
    dig_sel = sel;
    seg     = pat;
    tick(n);
  endtask

  task automatic drive(input int idx, input logic [6:0] pat, input int n);
    logic [ND-1:0] one;
    one = 1;
    drive_raw(one << idx, pat, n);
  endtask

  task automatic expect_frame(input logic [4*ND-1:0] bcd, input logic [ND-1:0] err);
    frame_t f;
    f.bcd = bcd;
    f.err = err;
    sb.push_back(f);
  endtask

  // Scoreboard side: outputs sampled on the falling edge, a transfer is
  // pending whenever valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL frame_unexpected observed=%h expected=none", bcd_out);
      end
      if (sb.size() != 0) begin
        frame_t e;
        e = sb.pop_front();
        checks++;
        assert (bcd_out === e.bcd) else begin
          failures++;
          $error("FAIL frame_bcd observed=%h expected=%h", bcd_out, e.bcd);
        end
        checks++;
        assert (err_mask === e.err) else begin
          failures++;
          $error("FAIL frame_err observed=%b expected=%b", err_mask, e.err);
        end
      end
    end
    if (overrun) ovr_cnt++;
  end

  initial begin
    rst       = 1'b1;
    seg       = '0;
    dig_sel   = '0;
    out_ready = 1'b1;
    tick(3);
    check("rst_valid",   32'(out_valid), 32'h0);
    check("rst_bcd",     32'(bcd_out),   32'hFFFF);
    check("rst_err",     32'(err_mask),  32'h0);
    check("rst_overrun", 32'(overrun),   32'h0);
    rst = 1'b0;
    tick(2);

    // Basic frame.
    expect_frame(16'h4321, 4'b0000);
    drive(0, P1, 10);
    drive(1, P2, 10);
    drive(2, P3, 10);
    drive(3, P4, 10);
    check("basic_drained", 32'(sb.size()), 32'h0);

    // Glitch rejection: 3-cycle dwell of "3" on digit 0 must not capture.
    expect_frame(16'h7651, 4'b0000);
    drive(0, P3, 3);
    drive(0, P1, 8);
    drive(1, P5, 10);
    drive(2, P6, 10);
    drive(3, P7, 10);
    check("glitch_drained", 32'(sb.size()), 32'h0);

    // Illegal and blank patterns.
    expect_frame(16'hFE98, 4'b0100);
    drive(0, P8, 10);
    drive(1, P9, 10);
    drive(2, PILL, 10);
    drive(3, PBLK, 10);
    check("illegal_drained", 32'(sb.size()), 32'h0);

    // Backpressure: second frame is dropped with one overrun pulse.
    out_ready = 1'b0;
    ovr_cnt   = 0;
    expect_frame(16'h5555, 4'b0000);
    for (int i = 0; i < ND; i++) drive(i, P5, 10);
    check("bp_first_valid", 32'(out_valid), 32'h1);
    check("bp_first_bcd",   32'(bcd_out),   32'h5555);
    for (int i = 0; i < ND; i++) drive(i, P9, 10);
    check("bp_held_valid", 32'(out_valid), 32'h1);
    check("bp_held_bcd",   32'(bcd_out),   32'h5555);
    check("bp_held_err",   32'(err_mask),  32'h0);
    check("bp_overruns",   32'(ovr_cnt),   32'h1);
    out_ready = 1'b1;
    tick(1);
    check("bp_valid_drop", 32'(out_valid), 32'h0);
    check("bp_drained",    32'(sb.size()), 32'h0);

    // Invalid selects: no capture, so digits 1..3 alone must not complete.
    drive_raw(4'b0011, P7, 20);
    check("inv_multi_valid", 32'(out_valid), 32'h0);
    drive_raw(4'b0000, P7, 20);
    check("inv_zero_valid", 32'(out_valid), 32'h0);
    drive(1, P2, 10);
    drive(2, P3, 10);
    drive(3, P4, 10);
    check("inv_partial_valid", 32'(out_valid), 32'h0);
    expect_frame(16'h4321, 4'b0000);
    drive(0, P1, 10);
    check("inv_drained", 32'(sb.size()), 32'h0);

    // Reset mid-frame: partially collected digits are lost.
    drive(0, P8, 10);
    drive(1, P8, 10);
    rst = 1'b1;
    tick(2);
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_bcd",   32'(bcd_out),   32'hFFFF);
    rst = 1'b0;
    expect_frame(16'h9876, 4'b0000);
    drive(0, P6, 10);
    drive(1, P7, 10);
    drive(2, P8, 10);
    drive(3, P9, 10);
    tick(5);
    check("final_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sev_segment_capture.md
# sev_segment_capture

Receive-side counterpart of the team's BCD-to-seven-segment encoder: watches a multiplexed seven-segment bus (segment lines plus one-hot digit select), waits for each digit's pattern to settle, decodes it back to BCD and assembles one word per scan frame. It sits in the self-check and loopback path, so display drive can be verified in hardware. Completed frames are offered on a valid/ready output port.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits; must be at least 2.
- STABLE_CYCLES, 4, consecutive identical samples needed before a digit is captured; must be at least 2.
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- seg  in  7  segment pattern {a,b,c,d,e,f,g}, a = bit 6, active-high.
- dig_sel  in  NUM_DIGITS  digit select, one-hot, bit i = digit i.
- out_ready  in  1  consumer accepts the frame.
- out_valid  out  1  frame available.
- bcd_out  out  4*NUM_DIGITS  digit i in bits [4i+3:4i].
- err_mask  out  NUM_DIGITS  bit i set = digit i held an unrecognised pattern.
- overrun  out  1  one-cycle pulse when a completed frame is dropped.

## Operation
- Decode table, the exact inverse of the encoder:
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4.
  - 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9.
  - 0000000 (blank) → 4'hF with error bit 0.
  - Any other pattern → 4'hE with error bit 1.
- Input stage: seg and dig_sel are registered once (s_seg, s_sel). All further logic uses these registered values.
- Stability counter stab_cnt, width clog2(STABLE_CYCLES)+1:
  - Reset to 1 when {s_seg, s_sel} differs from the previous registered sample.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Per-sample FSM, states WAIT and LOCKED:
  - WAIT → LOCKED when stab_cnt reaches STABLE_CYCLES and s_sel is exactly one-hot. Capture happens on that transition: write the decoded digit and error bit into slot i, and set seen[i].
  - LOCKED → WAIT on any change of s_seg or s_sel. This allows one capture per dwell.
  - s_sel zero or multi-hot: stay in or return to WAIT; no capture.
- Frame assembly:
  - When every bit of seen is set, the collected slots form one frame and seen is cleared on the same edge.
  - A recapture of an already-seen digit before the frame completes overwrites that slot.
- Output register:
  - The frame loads into bcd_out/err_mask and out_valid goes to 1 when out_valid=0, or when out_valid=1 and out_ready=1 on the same edge.
  - Otherwise the new frame is discarded, the held output is unchanged, and overrun pulses for one cycle.
  - out_valid clears when out_ready=1 and no new frame loads on that edge.
- Reset values: out_valid=0, bcd_out=all 4'hF, err_mask=0, overrun=0, seen=0, state=WAIT, stab_cnt=0, s_seg=0, s_sel=0.
- Reset mid-operation: a partially collected frame is lost.

## Timing
- Capture edge: the edge at which stab_cnt reaches STABLE_CYCLES. The pair must be stable at the input pins for STABLE_CYCLES+1 edges, including the input register.
- Frame-to-output: out_valid rises on the edge after the last digit's capture edge.
- Handshake: bcd_out/err_mask are stable while out_valid=1 && out_ready=0. A transfer occurs on every edge with both high.
- Simultaneous frame completion and accept in one cycle: the new frame loads; there is no gap and no overrun.
- overrun is exactly one cycle wide per dropped frame.

## Structure
- Shared package sev_segment_pkg holds:
  - the ten segment constants (SEG_0..SEG_9) and SEG_BLANK;
  - BCD_BLANK=4'hF and BCD_ERR=4'hE;
  - the FSM state typedef (WAIT, LOCKED).
  - The encoder uses the same constants.
- One combinational sub-module, sev_segment_decode (seg → bcd, err), instantiated once. The capture, FSM and frame logic stay in the top module.

## Test plan
- Basic frame:
  - Stimulus: NUM_DIGITS=4, STABLE_CYCLES=4; drive digits 0..3 with patterns for 1,2,3,4, 10 cycles each.
  - Required: out_valid rises; bcd_out=16'h4321, err_mask=0.
- Glitch rejection:
  - Stimulus: digit 0 holds 1111001 for 3 cycles only, then 8 cycles of 0110000.
  - Required: slot 0 = 1, never 3.
- Illegal and blank:
  - Stimulus: digit 2 = 1000000, digit 3 = 0000000.
  - Required: bcd_out[15:8]=8'hFE, err_mask=4'b0100.
- Backpressure:
  - Stimulus: hold out_ready=0 across two full frames (digits 5 then 9).
  - Required: bcd_out keeps the first frame; overrun pulses once.
  - Then raise out_ready for one cycle; required: out_valid drops.
- Invalid select:
  - Stimulus: dig_sel=4'b0011 and then 4'b0000, each for 20 cycles.
  - Required: no capture, seen unchanged, out_valid stays 0.
- Reset mid-frame:
  - Stimulus: assert rst after digits 0 and 1 are captured, then complete a full frame.
  - Required: exactly one frame is output, containing only the post-reset values.
